// File: rtl/debouncer_multi_ch.sv
// Multi-channel debouncer: one four-state FSM and stability counter per channel.
// Define DEBOUNCE_SYNC_EN to put a two-flop synchroniser in front of every channel.
module debouncer_multi_ch #(
    parameter int CHANNELS     = 4,
    parameter int DELAY_CYCLES = 1000000,
    parameter bit RESET_LEVEL  = 1'b0
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [CHANNELS-1:0] noisy,
    output logic [CHANNELS-1:0] debounced,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic [CHANNELS-1:0] busy
);

    localparam int CW = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
    localparam logic [CW-1:0] TERM = CW'(DELAY_CYCLES - 1);

    typedef enum logic [1:0] {
        STABLE_LO = 2'b00,
        WAIT_HI   = 2'b01,
        STABLE_HI = 2'b10,
        WAIT_LO   = 2'b11
    } state_t;

    localparam state_t HOME = RESET_LEVEL ? STABLE_HI : STABLE_LO;

    logic [CHANNELS-1:0] samp_s;

`ifdef DEBOUNCE_SYNC_EN
    logic [CHANNELS-1:0] meta_r;
    logic [CHANNELS-1:0] sync_r;

    // Two-flop synchroniser, parked at the reset level so reset exit is pulse-free.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_r <= {CHANNELS{RESET_LEVEL}};
            sync_r <= {CHANNELS{RESET_LEVEL}};
        end else begin
            meta_r <= noisy;
            sync_r <= meta_r;
        end
    end

    assign samp_s = sync_r;
`else
    assign samp_s = noisy;
`endif

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        state_t        state_r;
        state_t        state_nxt_s;
        logic [CW-1:0] cnt_r;
        logic [CW-1:0] cnt_nxt_s;
        logic          deb_nxt_s;
        logic          busy_nxt_s;
        logic          deb_r;
        logic          rise_r;
        logic          fall_r;
        logic          busy_r;

        // Next-state and counter logic; the terminal compare always leaves WAIT, so cnt never wraps.
        always_comb begin
            state_nxt_s = state_r;
            cnt_nxt_s   = cnt_r;
            case (state_r)
                STABLE_LO: begin
                    if (samp_s[i]) begin
                        state_nxt_s = WAIT_HI;
                        cnt_nxt_s   = {CW{1'b0}};
                    end else begin
                        state_nxt_s = STABLE_LO;
                    end
                end
                WAIT_HI: begin
                    if (!samp_s[i]) begin
                        state_nxt_s = STABLE_LO;
                    end else if (cnt_r == TERM) begin
                        state_nxt_s = STABLE_HI;
                    end else begin
                        cnt_nxt_s = cnt_r + CW'(1'b1);
                    end
                end
                STABLE_HI: begin
                    if (!samp_s[i]) begin
                        state_nxt_s = WAIT_LO;
                        cnt_nxt_s   = {CW{1'b0}};
                    end else begin
                        state_nxt_s = STABLE_HI;
                    end
                end
                WAIT_LO: begin
                    if (samp_s[i]) begin
                        state_nxt_s = STABLE_HI;
                    end else if (cnt_r == TERM) begin
                        state_nxt_s = STABLE_LO;
                    end else begin
                        cnt_nxt_s = cnt_r + CW'(1'b1);
                    end
                end
                default: begin
                    state_nxt_s = HOME;
                end
            endcase
            deb_nxt_s  = (state_nxt_s == STABLE_HI) || (state_nxt_s == WAIT_LO);
            busy_nxt_s = (state_nxt_s == WAIT_HI) || (state_nxt_s == WAIT_LO);
        end

        // State, counter and registered outputs; edge pulses come from comparing old and new level.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                state_r <= HOME;
                cnt_r   <= {CW{1'b0}};
                deb_r   <= RESET_LEVEL;
                rise_r  <= 1'b0;
                fall_r  <= 1'b0;
                busy_r  <= 1'b0;
            end else begin
                state_r <= state_nxt_s;
                cnt_r   <= cnt_nxt_s;
                deb_r   <= deb_nxt_s;
                rise_r  <= deb_nxt_s & ~deb_r;
                fall_r  <= ~deb_nxt_s & deb_r;
                busy_r  <= busy_nxt_s;
            end
        end

        assign debounced[i] = deb_r;
        assign rise[i]      = rise_r;
        assign fall[i]      = fall_r;
        assign busy[i]      = busy_r;
    end

endmodule

// File: tb/tb_debouncer_multi_ch.sv
// Bench for debouncer_multi_ch: two instances (D=8/level 0 and D=3/level 1) against
// a run-length reference model; directed scenarios followed by random toggling.
module tb_debouncer_multi_ch;

    localparam int DA = 8;
    localparam int DB = 3;
`ifdef DEBOUNCE_SYNC_EN
    localparam int L   = 2;
    localparam bit SYN = 1'b1;
`else
    localparam int L   = 0;
    localparam bit SYN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] noisy_a, noisy_b;
    logic [3:0] deb_a, rise_a, fall_a, busy_a;
    logic [3:0] deb_b, rise_b, fall_b, busy_b;

    int n_chk = 0;
    int n_pass = 0;

    debouncer_multi_ch #(.CHANNELS(4), .DELAY_CYCLES(DA), .RESET_LEVEL(1'b0)) dut_a (
        .clk(clk), .reset_n(reset_n), .noisy(noisy_a),
        .debounced(deb_a), .rise(rise_a), .fall(fall_a), .busy(busy_a));

    debouncer_multi_ch #(.CHANNELS(4), .DELAY_CYCLES(DB), .RESET_LEVEL(1'b1)) dut_b (
        .clk(clk), .reset_n(reset_n), .noisy(noisy_b),
        .debounced(deb_b), .rise(rise_b), .fall(fall_b), .busy(busy_b));

    always #5 clk = ~clk;

    // Reference model: the level flips once the sampled input has differed from it
    // for DELAY+1 consecutive edges; any agreeing sample clears the run.
    logic [3:0] e_deb[2], e_rise[2], e_fall[2], e_busy[2];
    logic [3:0] m_s1[2], m_s2[2];
    int         m_run[2][4];

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < 2; k++) begin
                e_deb[k]  <= (k == 0) ? 4'h0 : 4'hF;
                m_s1[k]   <= (k == 0) ? 4'h0 : 4'hF;
                m_s2[k]   <= (k == 0) ? 4'h0 : 4'hF;
                e_rise[k] <= 4'h0;
                e_fall[k] <= 4'h0;
                e_busy[k] <= 4'h0;
                for (int c = 0; c < 4; c++) m_run[k][c] <= 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                for (int c = 0; c < 4; c++) begin
                    logic nz;
                    logic s_in;
                    int   run;
                    int   dly;
                    nz   = (k == 0) ? noisy_a[c] : noisy_b[c];
                    dly  = (k == 0) ? DA : DB;
                    s_in = SYN ? m_s2[k][c] : nz;
                    m_s1[k][c] <= nz;
                    m_s2[k][c] <= m_s1[k][c];
                    run = (s_in != e_deb[k][c]) ? m_run[k][c] + 1 : 0;
                    if (run == dly + 1) begin
                        e_deb[k][c]  <= s_in;
                        e_rise[k][c] <= s_in;
                        e_fall[k][c] <= ~s_in;
                        run = 0;
                    end else begin
                        e_rise[k][c] <= 1'b0;
                        e_fall[k][c] <= 1'b0;
                    end
                    m_run[k][c]  <= run;
                    e_busy[k][c] <= (run != 0);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        noisy_a = 4'h0;
        noisy_b = 4'h0;
        #1 reset_n = 1'b0;
        #2;
        n_chk++; if (deb_b !== 4'hF) $display("FAIL reset_deb_b got %h exp f", deb_b); else n_pass++;
        n_chk++; if (deb_a !== 4'h0) $display("FAIL reset_deb_a got %h exp 0", deb_a); else n_pass++;
        n_chk++;
        if ({rise_a, fall_a, busy_a, rise_b, fall_b, busy_b} !== 24'h0)
            $display("FAIL reset_pulses got %h exp 0", {rise_a, fall_a, busy_a, rise_b, fall_b, busy_b});
        else n_pass++;
        @(negedge clk);
        reset_n = 1'b1;
        for (int e = 1; e <= DB + L + 3; e++) begin
            tick();
            n_chk++;
            if (fall_b !== ((e == DB + 1 + L) ? 4'hF : 4'h0))
                $display("FAIL reset_exit_fall edge %0d got %h", e, fall_b);
            else n_pass++;
            n_chk++;
            if ({deb_b, rise_b, fall_b, busy_b} !== {e_deb[1], e_rise[1], e_fall[1], e_busy[1]})
                $display("FAIL reset_model_b got %h exp %h", {deb_b, rise_b, fall_b, busy_b},
                         {e_deb[1], e_rise[1], e_fall[1], e_busy[1]});
            else n_pass++;
        end
    endtask

    task automatic test_clean_press();
        noisy_a[0] = 1'b1;
        for (int e = 1; e <= DA + L + 3; e++) begin
            tick();
            n_chk++;
            if (busy_a !== {3'b000, (e >= 1 + L) && (e <= DA + L)})
                $display("FAIL press_busy edge %0d got %h", e, busy_a);
            else n_pass++;
            n_chk++;
            if (rise_a !== ((e == DA + 1 + L) ? 4'h1 : 4'h0))
                $display("FAIL press_rise edge %0d got %h", e, rise_a);
            else n_pass++;
            n_chk++;
            if (deb_a !== ((e >= DA + 1 + L) ? 4'h1 : 4'h0))
                $display("FAIL press_deb edge %0d got %h", e, deb_a);
            else n_pass++;
        end
    endtask

    task automatic test_bounce();
        logic [5:0] pat;
        int         rises;
        pat   = 6'b101101;
        rises = 0;
        for (int e = 1; e <= DA + L + 9; e++) begin
            noisy_a[1] = (e <= 6) ? pat[6 - e] : 1'b1;
            tick();
            rises += rise_a[1];
            n_chk++;
            if (rise_a[1] !== (e == 6 + DA + L))
                $display("FAIL bounce_rise edge %0d got %b", e, rise_a[1]);
            else n_pass++;
            n_chk++;
            if ({deb_a, rise_a, fall_a, busy_a} !== {e_deb[0], e_rise[0], e_fall[0], e_busy[0]})
                $display("FAIL bounce_model got %h exp %h", {deb_a, rise_a, fall_a, busy_a},
                         {e_deb[0], e_rise[0], e_fall[0], e_busy[0]});
            else n_pass++;
        end
        n_chk++; if (rises != 1) $display("FAIL bounce_count got %0d exp 1", rises); else n_pass++;
    endtask

    task automatic test_glitch();
        int falls;
        falls = 0;
        noisy_a[2] = 1'b1;
        repeat (DA + 1 + L) tick();
        n_chk++; if (deb_a[2] !== 1'b1) $display("FAIL glitch_setup got %b exp 1", deb_a[2]); else n_pass++;
        for (int e = 1; e <= DA + L + 9; e++) begin
            noisy_a[2] = (e == 6);
            tick();
            falls += fall_a[2];
            n_chk++;
            if (fall_a[2] !== (e == 7 + DA + L))
                $display("FAIL glitch_fall edge %0d got %b", e, fall_a[2]);
            else n_pass++;
        end
        n_chk++; if (falls != 1) $display("FAIL glitch_count got %0d exp 1", falls); else n_pass++;
    endtask

    task automatic test_simultaneous();
        noisy_b = 4'hF;
        for (int e = 1; e <= DB + L + 3; e++) begin
            tick();
            n_chk++;
            if (rise_b !== ((e == DB + 1 + L) ? 4'hF : 4'h0))
                $display("FAIL simul_rise edge %0d got %h", e, rise_b);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        noisy_a[3] = 1'b1;
        repeat (6 + L) tick();
        n_chk++; if (busy_a[3] !== 1'b1) $display("FAIL mid_busy got %b exp 1", busy_a[3]); else n_pass++;
        reset_n = 1'b0;
        #2;
        n_chk++;
        if ({deb_a, rise_a, fall_a, busy_a} !== 16'h0)
            $display("FAIL mid_reset got %h exp 0", {deb_a, rise_a, fall_a, busy_a});
        else n_pass++;
        #1 reset_n = 1'b1;
        for (int e = 1; e <= DA + L + 3; e++) begin
            tick();
            n_chk++;
            if (rise_a !== ((e == DA + 1 + L) ? 4'b1011 : 4'b0000))
                $display("FAIL mid_restart_rise edge %0d got %h", e, rise_a);
            else n_pass++;
            n_chk++;
            if ({deb_b, rise_b, fall_b, busy_b} !== {e_deb[1], e_rise[1], e_fall[1], e_busy[1]})
                $display("FAIL mid_model_b got %h exp %h", {deb_b, rise_b, fall_b, busy_b},
                         {e_deb[1], e_rise[1], e_fall[1], e_busy[1]});
            else n_pass++;
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 800; n++) begin
            for (int c = 0; c < 4; c++) begin
                if ($urandom_range(0, 11) == 0) noisy_a[c] = ~noisy_a[c];
                if ($urandom_range(0, 5) == 0) noisy_b[c] = ~noisy_b[c];
            end
            tick();
            n_chk++;
            if ({deb_a, rise_a, fall_a, busy_a} !== {e_deb[0], e_rise[0], e_fall[0], e_busy[0]})
                $display("FAIL rand_a cycle %0d got %h exp %h", n, {deb_a, rise_a, fall_a, busy_a},
                         {e_deb[0], e_rise[0], e_fall[0], e_busy[0]});
            else n_pass++;
            n_chk++;
            if ({deb_b, rise_b, fall_b, busy_b} !== {e_deb[1], e_rise[1], e_fall[1], e_busy[1]})
                $display("FAIL rand_b cycle %0d got %h exp %h", n, {deb_b, rise_b, fall_b, busy_b},
                         {e_deb[1], e_rise[1], e_fall[1], e_busy[1]});
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_glitch();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
